// File: rtl/sonar_serial_rx.sv
// Sonar link receiver: 7E2 UART deserialiser plus "AAA,DDD#" frame decoder with BCD outputs.
// Optional build macro SONAR_RX_PARITY_CHECK_EN enables the even-parity check.
module sonar_serial_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] ang_centena,
  output logic [3:0] ang_dezena,
  output logic [3:0] ang_unidade,
  output logic [3:0] dist_centena,
  output logic [3:0] dist_dezena,
  output logic [3:0] dist_unidade,
  output logic       quadro_pronto,
  output logic       erro_paridade,
  output logic       erro_formato,
  output logic [3:0] db_estado
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [6:0] CH_COMMA = 7'h2C;
  localparam logic [6:0] CH_HASH  = 7'h23;

  logic [1:0]       r_rxSync;
  logic             r_rxPrev;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_bitIdx;
  logic [6:0]       r_data;
  logic [2:0]       r_index;
  logic [3:0]       r_shA2, r_shA1, r_shA0, r_shD2, r_shD1, r_shD0;
  logic [3:0]       r_angC, r_angD, r_angU, r_distC, r_distD, r_distU;
  logic             r_quadroPronto;
  logic             r_erroFormato;

  logic w_rx;
  logic w_fallEdge;
  logic w_tick;
  logic w_stopErr;
  logic w_isDigit;

  assign w_rx       = r_rxSync[1];
  assign w_fallEdge = r_rxPrev & ~w_rx;
  assign w_tick     = (r_count == BIT_M1);
  assign w_stopErr  = ((r_state == S_STOP1) || (r_state == S_STOP2)) && w_tick && !w_rx;
  assign w_isDigit  = (r_data >= 7'h30) && (r_data <= 7'h39);

  // Synchroniser resets to idle-high so release of reset never looks like a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rxSync <= 2'b11;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxSync <= {r_rxSync[0], rx};
      r_rxPrev <= w_rx;
    end
  end

`ifdef SONAR_RX_PARITY_CHECK_EN
  logic r_parityBit;
  logic r_erroParidade;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_bitIdx <= '0;
      r_data   <= '0;
`ifdef SONAR_RX_PARITY_CHECK_EN
      r_parityBit <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (w_fallEdge) r_state <= S_START;
        end
        S_START: begin
          if (r_count == HALF_M1) begin
            r_count  <= '0;
            r_bitIdx <= '0;
            r_state  <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_count  <= '0;
            r_data   <= {w_rx, r_data[6:1]};
            r_bitIdx <= r_bitIdx + 1'b1;
            if (r_bitIdx == 3'd6) r_state <= S_PARITY;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_count <= '0;
`ifdef SONAR_RX_PARITY_CHECK_EN
            r_parityBit <= w_rx;
`endif
            r_state <= S_STOP1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_STOP1, S_STOP2: begin
          if (w_tick) begin
            r_count <= '0;
            if (!w_rx)                 r_state <= S_IDLE;
            else if (r_state == S_STOP1) r_state <= S_STOP2;
            else                       r_state <= S_DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_DONE: begin
          // A start edge landing in the DONE cycle itself is still honoured.
          r_count <= '0;
          r_state <= w_fallEdge ? S_START : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame parser: digits collect in shadows and reach the outputs only on a good '#'.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_index <= '0;
      {r_shA2, r_shA1, r_shA0, r_shD2, r_shD1, r_shD0} <= '0;
      {r_angC, r_angD, r_angU, r_distC, r_distD, r_distU} <= '0;
      r_quadroPronto <= 1'b0;
      r_erroFormato  <= 1'b0;
`ifdef SONAR_RX_PARITY_CHECK_EN
      r_erroParidade <= 1'b0;
`endif
    end else begin
      r_quadroPronto <= 1'b0;
      r_erroFormato  <= 1'b0;
`ifdef SONAR_RX_PARITY_CHECK_EN
      r_erroParidade <= 1'b0;
`endif
      if (w_stopErr) begin
        r_erroFormato <= 1'b1;
        r_index       <= '0;
      end else if (r_state == S_DONE) begin
`ifdef SONAR_RX_PARITY_CHECK_EN
        if (r_parityBit != ^r_data) begin
          r_erroParidade <= 1'b1;
          r_index        <= '0;
        end else
`endif
        if (r_index == 3'd7) begin
          if (r_data == CH_HASH) begin
            {r_angC, r_angD, r_angU}    <= {r_shA2, r_shA1, r_shA0};
            {r_distC, r_distD, r_distU} <= {r_shD2, r_shD1, r_shD0};
            r_quadroPronto <= 1'b1;
          end else begin
            r_erroFormato <= 1'b1;
          end
          r_index <= '0;
        end else if (r_index == 3'd3) begin
          if (r_data == CH_COMMA) begin
            r_index <= r_index + 1'b1;
          end else begin
            r_erroFormato <= 1'b1;
            r_index       <= '0;
          end
        end else if (w_isDigit) begin
          case (r_index)
            3'd0:    r_shA2 <= r_data[3:0];
            3'd1:    r_shA1 <= r_data[3:0];
            3'd2:    r_shA0 <= r_data[3:0];
            3'd4:    r_shD2 <= r_data[3:0];
            3'd5:    r_shD1 <= r_data[3:0];
            default: r_shD0 <= r_data[3:0];
          endcase
          r_index <= r_index + 1'b1;
        end else begin
          r_erroFormato <= 1'b1;
          r_index       <= '0;
        end
      end
    end
  end

  assign ang_centena   = r_angC;
  assign ang_dezena    = r_angD;
  assign ang_unidade   = r_angU;
  assign dist_centena  = r_distC;
  assign dist_dezena   = r_distD;
  assign dist_unidade  = r_distU;
  assign quadro_pronto = r_quadroPronto;
  assign erro_formato  = r_erroFormato;
  assign db_estado     = {1'b0, r_state};
`ifdef SONAR_RX_PARITY_CHECK_EN
  assign erro_paridade = r_erroParidade;
`else
  assign erro_paridade = 1'b0;
`endif

endmodule

// File: tb/tb_sonar_serial_rx.sv
// Scoreboard bench for sonar_serial_rx: directed frames, expected pulses queued, monitor compares.
module tb_sonar_serial_rx;

  localparam int CPB = 40;
  localparam int K_FRAME  = 0;
  localparam int K_PARITY = 1;
  localparam int K_FORMAT = 2;

  typedef struct {
    int          kind;
    logic [23:0] digits;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] ang_centena, ang_dezena, ang_unidade;
  logic [3:0] dist_centena, dist_dezena, dist_unidade;
  logic       quadro_pronto, erro_paridade, erro_formato;
  logic [3:0] db_estado;

  int          total = 0;
  int          bad   = 0;
  exp_t        expQ[$];
  logic [23:0] lastDigits = '0;
  logic [23:0] w_digits;

  assign w_digits = {ang_centena, ang_dezena, ang_unidade, dist_centena, dist_dezena, dist_unidade};

  sonar_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .ang_centena(ang_centena),
    .ang_dezena(ang_dezena),
    .ang_unidade(ang_unidade),
    .dist_centena(dist_centena),
    .dist_dezena(dist_dezena),
    .dist_unidade(dist_unidade),
    .quadro_pronto(quadro_pronto),
    .erro_paridade(erro_paridade),
    .erro_formato(erro_formato),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expectEvent(input int kind, input logic [23:0] digits);
    exp_t e;
    e.kind   = kind;
    e.digits = digits;
    expQ.push_back(e);
  endtask

  task automatic bitOut(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [6:0] c, input bit flipParity);
    bitOut(1'b0);
    for (int i = 0; i < 7; i++) bitOut(c[i]);
    bitOut((^c) ^ flipParity);
    bitOut(1'b1);
    bitOut(1'b1);
  endtask

  task automatic sendStr(input string s);
    byte ch;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      applyStimulus(ch[6:0], 1'b0);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard queue.
  always @(negedge clock) begin
    exp_t e;
    int   kind;
    if (reset === 1'b1 && (quadro_pronto || erro_paridade || erro_formato)) begin
      checkOutput("pulse_exclusive", 32'(quadro_pronto + erro_paridade + erro_formato), 32'd1);
      kind = quadro_pronto ? K_FRAME : (erro_paridade ? K_PARITY : K_FORMAT);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", 32'(kind), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse_kind", 32'(kind), 32'(e.kind));
        if (kind == K_FRAME) begin
          checkOutput("frame_digits", {8'h0, w_digits}, {8'h0, e.digits});
          lastDigits = e.digits;
        end else begin
          checkOutput("digits_hold", {8'h0, w_digits}, {8'h0, lastDigits});
        end
      end
    end
  end

  task automatic drainCheck(input string name);
    repeat (2 * CPB) @(negedge clock);
    checkOutput(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("reset_digits", {8'h0, w_digits}, 32'h0);
    checkOutput("reset_state", {28'h0, db_estado}, 32'h0);
    checkOutput("reset_pulses", {29'h0, quadro_pronto, erro_paridade, erro_formato}, 32'h0);
    reset = 1'b1;
    repeat (3 * CPB) @(negedge clock);

    expectEvent(K_FRAME, 24'h045123);
    sendStr("045,123#");
    drainCheck("drain_frame1");

    expectEvent(K_FRAME, 24'h180020);
    expectEvent(K_FRAME, 24'h090300);
    sendStr("180,020#");
    sendStr("090,300#");
    drainCheck("drain_b2b");

    // 'x' aborts; each of ",...#" then mismatches at position 0.
    for (int i = 0; i < 6; i++) expectEvent(K_FORMAT, 24'h0);
    sendStr("04x,...#");
    expectEvent(K_FRAME, 24'h010050);
    sendStr("010,050#");
    drainCheck("drain_format");

`ifdef SONAR_RX_PARITY_CHECK_EN
    expectEvent(K_PARITY, 24'h0);
    expectEvent(K_FORMAT, 24'h0);
`else
    expectEvent(K_FRAME, 24'h111222);
`endif
    sendStr("111");
    applyStimulus(7'h2C, 1'b1);
    sendStr("222#");
    drainCheck("drain_parity");

    rx = 1'b0;
    repeat (10) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    checkOutput("glitch_state", {28'h0, db_estado}, 32'h0);
    checkOutput("glitch_digits", {8'h0, w_digits}, {8'h0, lastDigits});

    sendStr("999,8");
    bitOut(1'b0);
    bitOut(1'b0);
    bitOut(1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    lastDigits = '0;
    checkOutput("midreset_digits", {8'h0, w_digits}, 32'h0);
    checkOutput("midreset_state", {28'h0, db_estado}, 32'h0);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    checkOutput("postreset_state", {28'h0, db_estado}, 32'h0);

    expectEvent(K_FRAME, 24'h123456);
    sendStr("123,456#");
    drainCheck("drain_final");
    checkOutput("final_digits", {8'h0, w_digits}, 32'h00123456);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
